// File: rtl/app_dma_pkg.sv
// Shared types and constants for the DDR3 app-interface write DMA.
package app_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } wr_state_t;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

endpackage

// File: rtl/app_dma_beat_cnt.sv
// Accepted-transfer counter with below-limit compare and next-cycle terminal detect.
module app_dma_beat_cnt #(
  parameter int LEN_W = 8
) (
  input  logic             I_sys_clk,
  input  logic             I_Rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [LEN_W-1:0] len,
  input  logic [LEN_W:0]   lim,
  output logic [LEN_W-1:0] cnt,
  output logic             below,
  output logic             done_nxt
);

  logic [LEN_W:0] cnt_nxt;

  assign cnt_nxt  = {1'b0, cnt} + {{LEN_W{1'b0}}, inc};
  assign below    = (cnt < len) && ({1'b0, cnt} < lim);
  assign done_nxt = (cnt_nxt == {1'b0, len});

  always_ff @(posedge I_sys_clk) begin
    if (!I_Rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt_nxt[LEN_W-1:0];
    end
  end

endmodule

// File: rtl/app_dma_wr_gen.sv
// Burst write generator for a DDR3 app interface; data and command paths run independently.
// Optional address ring wrap enabled by defining APP_DMA_WR_RING_EN.
//
// state   | meaning
// IDLE    | waiting for ex_wr_start
// RUN     | issuing data beats and write commands
// DONE    | one-cycle burst_end, back to IDLE
module app_dma_wr_gen
  import app_dma_pkg::*;
#(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 256,
  parameter int LEN_W     = 8,
  parameter int ADDR_STEP = 8,
  parameter int CMD_LEAD  = 0
) (
  input  logic                I_sys_clk,
  input  logic                I_Rst_n,
  input  logic                ex_wr_start,
  input  logic [ADDR_W-1:0]   ex_wr_addr,
  input  logic [LEN_W-1:0]    ex_wr_burst_len,
  input  logic [DATA_W-1:0]   ex_wr_data,
  input  logic [DATA_W/8-1:0] ex_wr_wdf_mask,
  output logic                ex_wr_busy,
  output logic                ex_wr_burst_start,
  output logic                ex_wr_burst_end,
  output logic                ex_wr_rd_en,
  output logic                ex_wr_err,
  output logic [ADDR_W-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  input  logic                app_rdy,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  input  logic                app_wdf_rdy,
  output logic [DATA_W/8-1:0] app_wdf_mask
`ifdef APP_DMA_WR_RING_EN
  ,
  input  logic [ADDR_W-1:0]   ring_base,
  input  logic [ADDR_W-1:0]   ring_size
`endif
);

  wr_state_t state, state_nxt;

  logic [LEN_W-1:0]    len_q;
  logic [DATA_W/8-1:0] mask_q;
  logic                err_q;
  logic                accept;
  logic                data_inc, cmd_inc;
  logic [LEN_W-1:0]    data_cnt, cmd_cnt;
  logic                data_below, cmd_below;
  logic                data_done_nxt, cmd_done_nxt;
  logic [LEN_W:0]      cmd_lim;
  logic [ADDR_W-1:0]   addr_step, addr_nxt;

  assign accept   = (state == ST_IDLE) && ex_wr_start && (ex_wr_burst_len != '0);
  assign data_inc = app_wdf_wren & app_wdf_rdy;
  assign cmd_inc  = app_en & app_rdy;
  // Commands may run at most CMD_LEAD ahead of registered accepted beats.
  assign cmd_lim  = {1'b0, data_cnt} + (LEN_W+1)'(CMD_LEAD);

  app_dma_beat_cnt #(.LEN_W(LEN_W)) u_data_cnt (
    .I_sys_clk (I_sys_clk),
    .I_Rst_n   (I_Rst_n),
    .clr       (state == ST_IDLE),
    .inc       (data_inc),
    .len       (len_q),
    .lim       ({1'b0, len_q}),
    .cnt       (data_cnt),
    .below     (data_below),
    .done_nxt  (data_done_nxt)
  );

  app_dma_beat_cnt #(.LEN_W(LEN_W)) u_cmd_cnt (
    .I_sys_clk (I_sys_clk),
    .I_Rst_n   (I_Rst_n),
    .clr       (state == ST_IDLE),
    .inc       (cmd_inc),
    .len       (len_q),
    .lim       (cmd_lim),
    .cnt       (cmd_cnt),
    .below     (cmd_below),
    .done_nxt  (cmd_done_nxt)
  );

  always_ff @(posedge I_sys_clk) begin
    if (!I_Rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_RUN;
      ST_RUN:  if (data_done_nxt && cmd_done_nxt) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ex_wr_busy        = (state != ST_IDLE);
    ex_wr_burst_start = accept;
    ex_wr_burst_end   = (state == ST_DONE);
    app_wdf_wren      = (state == ST_RUN) && data_below;
    app_en            = (state == ST_RUN) && cmd_below;
  end

  assign app_cmd      = APP_CMD_WR;
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_data = ex_wr_data;
  assign app_wdf_mask = mask_q;
  assign ex_wr_rd_en  = app_wdf_wren & app_wdf_rdy;
  assign ex_wr_err    = err_q;

  assign addr_step = app_addr + ADDR_W'(ADDR_STEP);
`ifdef APP_DMA_WR_RING_EN
  logic [ADDR_W-1:0] ring_last;
  assign ring_last = ring_base + ring_size - ADDR_W'(ADDR_STEP);
  assign addr_nxt  = (addr_step > ring_last) ? ring_base : addr_step;
`else
  assign addr_nxt  = addr_step;
`endif

  always_ff @(posedge I_sys_clk) begin
    if (!I_Rst_n) begin
      app_addr <= '0;
      len_q    <= '0;
      mask_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= (state == ST_IDLE) && ex_wr_start && (ex_wr_burst_len == '0);
      if (accept) begin
        app_addr <= ex_wr_addr;
        len_q    <= ex_wr_burst_len;
        mask_q   <= ex_wr_wdf_mask;
      end else if (cmd_inc) begin
        app_addr <= addr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_app_dma_wr_gen.sv
// Directed bench for app_dma_wr_gen: one CMD_LEAD=0 instance and one CMD_LEAD=2 instance.
module tb_app_dma_wr_gen;
  localparam int AW = 28;
  localparam int DW = 256;
  localparam int LW = 8;
  localparam int MW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start;
  logic [AW-1:0] addr;
  logic [LW-1:0] len;
  logic [DW-1:0] wdata;
  logic [MW-1:0] wmask;
  logic          app_rdy, wdf_rdy, app_rdy2, wdf_rdy2;
  logic [AW-1:0] ring_base, ring_size;

  logic          busy, bstart, bend, rd_en, err, app_en, wren, wend;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic [DW-1:0] wdf_data;
  logic [MW-1:0] wmask_o;

  logic          busy2, bstart2, bend2, rd_en2, err2, app_en2, wren2, wend2;
  logic [AW-1:0] app_addr2;
  logic [2:0]    app_cmd2;
  logic [DW-1:0] wdf_data2;
  logic [MW-1:0] wmask_o2;

  app_dma_wr_gen #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ADDR_STEP(8), .CMD_LEAD(0)) dut (
    .I_sys_clk(clk), .I_Rst_n(rst_n), .ex_wr_start(start), .ex_wr_addr(addr),
    .ex_wr_burst_len(len), .ex_wr_data(wdata), .ex_wr_wdf_mask(wmask),
    .ex_wr_busy(busy), .ex_wr_burst_start(bstart), .ex_wr_burst_end(bend),
    .ex_wr_rd_en(rd_en), .ex_wr_err(err), .app_addr(app_addr), .app_cmd(app_cmd),
    .app_en(app_en), .app_rdy(app_rdy), .app_wdf_data(wdf_data), .app_wdf_wren(wren),
    .app_wdf_end(wend), .app_wdf_rdy(wdf_rdy), .app_wdf_mask(wmask_o)
`ifdef APP_DMA_WR_RING_EN
    , .ring_base(ring_base), .ring_size(ring_size)
`endif
  );

  app_dma_wr_gen #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ADDR_STEP(8), .CMD_LEAD(2)) dut2 (
    .I_sys_clk(clk), .I_Rst_n(rst_n), .ex_wr_start(start), .ex_wr_addr(addr),
    .ex_wr_burst_len(len), .ex_wr_data(wdata), .ex_wr_wdf_mask(wmask),
    .ex_wr_busy(busy2), .ex_wr_burst_start(bstart2), .ex_wr_burst_end(bend2),
    .ex_wr_rd_en(rd_en2), .ex_wr_err(err2), .app_addr(app_addr2), .app_cmd(app_cmd2),
    .app_en(app_en2), .app_rdy(app_rdy2), .app_wdf_data(wdf_data2), .app_wdf_wren(wren2),
    .app_wdf_end(wend2), .app_wdf_rdy(wdf_rdy2), .app_wdf_mask(wmask_o2)
`ifdef APP_DMA_WR_RING_EN
    , .ring_base(ring_base), .ring_size(ring_size)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitors sample at negedge: a handshake seen here is accepted at the next posedge.
  logic [MW-1:0] exp_mask;
  int nb, nc, nrd, tot_en, tot_wren, tot_err, tot_end, stall_bad, mask_bad, misc_bad;
  int nb2, nc2, early2;
  logic [AW-1:0] aq[$];
  logic          stall_p;
  logic [AW-1:0] stall_a;

  initial begin
    nb = 0; nc = 0; nrd = 0; tot_en = 0; tot_wren = 0; tot_err = 0; tot_end = 0;
    stall_bad = 0; mask_bad = 0; misc_bad = 0; nb2 = 0; nc2 = 0; early2 = 0;
    stall_p = 1'b0; stall_a = '0;
  end

  always @(negedge clk) begin
    if (bstart) begin
      nb <= 0; nc <= 0; nrd <= 0;
      aq.delete();
    end else begin
      if (app_en && app_rdy) begin
        nc <= nc + 1;
        aq.push_back(app_addr);
      end
      if (wren && wdf_rdy) nb <= nb + 1;
      if (rd_en) nrd <= nrd + 1;
    end
    if (stall_p && (!app_en || app_addr != stall_a)) stall_bad <= stall_bad + 1;
    stall_p <= app_en && !app_rdy;
    stall_a <= app_addr;
    if (app_en) tot_en <= tot_en + 1;
    if (wren) tot_wren <= tot_wren + 1;
    if (err) tot_err <= tot_err + 1;
    if (bend) tot_end <= tot_end + 1;
    if (wren && wmask_o != exp_mask) mask_bad <= mask_bad + 1;
    if (wend != wren || app_cmd != 3'b000 || wdf_data != wdata) misc_bad <= misc_bad + 1;
  end

  always @(negedge clk) begin
    if (bstart2) begin
      nb2 <= 0; nc2 <= 0; early2 <= 0;
    end else begin
      if (app_en2 && app_rdy2) begin
        nc2 <= nc2 + 1;
        if (nb2 == 0) early2 <= early2 + 1;
      end
      if (wren2 && wdf_rdy2) nb2 <= nb2 + 1;
    end
  end

  // Starts a burst at cycle 0; app_rdy low for cycles rlo..rhi, dut2 wdf_rdy low for wlo..whi.
  task automatic run_xfer(input logic [AW-1:0] a, input logic [LW-1:0] n,
                          input int rlo, input int rhi, input int wlo, input int whi,
                          output int ecyc);
    int k;
    ecyc = -1;
    addr = a; len = n; wmask = exp_mask; start = 1'b1;
    for (k = 0; k < 300; k++) begin
      app_rdy  = !(k >= rlo && k <= rhi);
      wdf_rdy2 = !(k >= wlo && k <= whi);
      @(negedge clk);
      if (k == 0) chk("burst_start", bstart, 1);
      if (bend && ecyc < 0) ecyc = k;
      @(posedge clk); #1;
      start = 1'b0;
      wmask = ~exp_mask;
      if (ecyc >= 0 && !busy && !busy2) break;
    end
    app_rdy = 1'b1; wdf_rdy2 = 1'b1;
    if (k >= 300) chk("xfer_timeout", k, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int e, base_err, base_en, base_w, base_end, base_stall;

  initial begin
    start = 1'b0; addr = '0; len = '0; wmask = '0; exp_mask = '0;
    wdata = {4{64'hDEAD_BEEF_0123_4567}};
    app_rdy = 1'b1; wdf_rdy = 1'b1; app_rdy2 = 1'b1; wdf_rdy2 = 1'b1;
    ring_base = '0; ring_size = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_app_en", app_en, 0);
    chk("rst_wren", wren, 0);
    chk("rst_mask", wmask_o, 0);
    chk("rst_addr", app_addr, 0);
    chk("rst_err", err, 0);
    chk("rst_bend", bend, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic len=4 burst
    exp_mask = 32'h0000_F00F;
    run_xfer(28'h100, 8'd4, -1, -1, -1, -1, e);
    chk("t1_end_cycle", e, 6);
    chk("t1_cmds", nc, 4);
    chk("t1_beats", nb, 4);
    chk("t1_rd_en", nrd, 4);
    for (int i = 0; i < 4; i++) chk("t1_addr", (i < aq.size()) ? aq[i] : 28'hFFFFFFF, 28'h100 + 28'(8 * i));

    // Zero-length request is an error
    base_err = tot_err; base_en = tot_en; base_w = tot_wren;
    len = 8'd0; addr = 28'h180; start = 1'b1;
    @(negedge clk);
    chk("t2_no_bstart", bstart, 0);
    chk("t2_err_c0", err, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("t2_err_c1", err, 1);
    chk("t2_busy", busy, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_err_c2", err, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t2_err_pulses", tot_err - base_err, 1);
    chk("t2_no_en", tot_en - base_en, 0);
    chk("t2_no_wren", tot_wren - base_w, 0);

    // len=8 with app_rdy low cycles 2..5
    base_stall = stall_bad;
    exp_mask = 32'h1234_5678;
    run_xfer(28'h200, 8'd8, 2, 5, -1, -1, e);
    chk("t3_end_cycle", e, 14);
    chk("t3_cmds", nc, 8);
    chk("t3_beats", nb, 8);
    chk("t3_stall_hold", stall_bad - base_stall, 0);
    chk("t3_addr_first", (aq.size() > 0) ? aq[0] : 28'hFFFFFFF, 28'h200);
    chk("t3_addr_last", (aq.size() > 7) ? aq[7] : 28'hFFFFFFF, 28'h238);

    // CMD_LEAD=2 instance with app_wdf_rdy low cycles 1..4
    exp_mask = 32'hA5A5_0000;
    run_xfer(28'h300, 8'd4, -1, -1, 1, 4, e);
    chk("t4_lead0_end", e, 6);
    chk("t4_early_cmds", early2, 2);
    chk("t4_lead_cmds", nc2, 4);
    chk("t4_lead_beats", nb2, 4);

    // Address wraps modulo 2^ADDR_W
    exp_mask = 32'hFFFF_FFFF;
    run_xfer(28'hFFFFFF8, 8'd2, -1, -1, -1, -1, e);
    chk("t5_end_cycle", e, 4);
    chk("t5_addr0", (aq.size() > 0) ? aq[0] : 28'h1, 28'hFFFFFF8);
    chk("t5_addr1", (aq.size() > 1) ? aq[1] : 28'h1, 28'h0000000);

    // Reset after the third beat of a len=16 burst
    base_end = tot_end;
    exp_mask = 32'h0F0F_0F0F;
    addr = 28'h400; len = 8'd16; wmask = exp_mask; start = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      @(posedge clk); #1;
      start = 1'b0;
      if (nb == 3) break;
    end
    chk("t6_reached_beat3", nb, 3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_rst_en", app_en, 0);
    chk("t6_rst_wren", wren, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_addr", app_addr, 0);
    chk("t6_rst_mask", wmask_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    base_en = tot_en; base_w = tot_wren;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_no_bend", tot_end - base_end, 0);
    chk("t6_quiet_en", tot_en - base_en, 0);
    chk("t6_quiet_wren", tot_wren - base_w, 0);
    exp_mask = 32'h00FF_00FF;
    run_xfer(28'h500, 8'd2, -1, -1, -1, -1, e);
    chk("t6_new_end", e, 4);
    chk("t6_new_cmds", nc, 2);
    chk("t6_new_beats", nb, 2);
    chk("t6_new_addr1", (aq.size() > 1) ? aq[1] : 28'h1, 28'h508);

`ifdef APP_DMA_WR_RING_EN
    ring_base = 28'h1000; ring_size = 28'h20;
    exp_mask = 32'h1111_2222;
    run_xfer(28'h1010, 8'd4, -1, -1, -1, -1, e);
    chk("t7_ring_a0", (aq.size() > 0) ? aq[0] : 28'h1, 28'h1010);
    chk("t7_ring_a1", (aq.size() > 1) ? aq[1] : 28'h1, 28'h1018);
    chk("t7_ring_a2", (aq.size() > 2) ? aq[2] : 28'h1, 28'h1000);
    chk("t7_ring_a3", (aq.size() > 3) ? aq[3] : 28'h1, 28'h1008);
    ring_base = '0; ring_size = '0;
`endif

    chk("mask_latched", mask_bad, 0);
    chk("passthrough", misc_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
